// File: rtl/tone_arb_pkg.sv
// rtl/tone_arb_pkg.sv - shared constants for the speaker tone arbiter
//
// Purpose: arbiter state encoding, tone code values and the fixed-priority
// pick helper shared by tone_arbiter and its testbench.
// Ports: none (package).

package tone_arb_pkg;

    // Arbiter states; the 2'd3 code is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Tone codes carried on tone0/tone1/tone2.
    localparam logic [1:0] TONE_OFF = 2'd0;
    localparam logic [1:0] TONE_LO  = 2'd1;
    localparam logic [1:0] TONE_MID = 2'd2;
    localparam logic [1:0] TONE_HI  = 2'd3;

    // Isolates the lowest set bit: req[0] is the highest priority.
    function automatic logic [2:0] lowest_onehot(input logic [2:0] r);
        return r & (~r + 3'd1);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave divider for one selectable half-period
//
// Purpose: counts clk cycles from 0 to half_period-1 and toggles the square
// bit at each wrap. restart clears the divider so a new tone begins low and
// first rises exactly half_period clks after the restart edge.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   restart      in   clear divider and square bit (wins over en)
//   half_period  in   half-period in clk cycles
//   en           in   advance the divider
//   sq_out       out  square bit

module tone_gen #(
    parameter int HALF_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [HALF_W-1:0] half_period,
    input  logic              en,
    output logic              sq_out
);

    localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              sq_q, sq_d;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (restart) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (en) begin
            // >= rather than == so a shrinking half_period can never strand
            // the counter above the wrap point.
            if (cnt_q >= half_period - ONE) begin
                cnt_d = '0;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign sq_out = sq_q;

endmodule

// File: rtl/tone_arbiter.sv
// rtl/tone_arbiter.sv - fixed-priority owner of the speaker output
//
// Purpose: grants the speaker to the lowest-index requester, holds the grant
// for at least MIN_HOLD_TICKS arbitration ticks, then forces GAP_TICKS of
// silence before the next grant. Drives aud_out with the granted tone.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   req      in   [2:0] request lines, req[0] highest priority
//   tone0    in   [1:0] tone code of requester 0
//   tone1    in   [1:0] tone code of requester 1
//   tone2    in   [1:0] tone code of requester 2
//   grant    out  [2:0] one-hot grant, zero when idle or in the gap
//   busy     out  high while holding or in the gap
//   aud_out  out  square-wave speaker drive

module tone_arbiter
    import tone_arb_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 100,
    parameter int MIN_HOLD_TICKS = 10,
    parameter int GAP_TICKS      = 2,
    parameter int TONE1_HALF     = 68493,
    parameter int TONE2_HALF     = 52632,
    parameter int TONE3_HALF     = 41667
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [1:0] tone0,
    input  logic [1:0] tone1,
    input  logic [1:0] tone2,
    output logic [2:0] grant,
    output logic       busy,
    output logic       aud_out
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    localparam int HALF_12  = (TONE1_HALF > TONE2_HALF) ? TONE1_HALF : TONE2_HALF;
    localparam int HALF_MAX = (HALF_12 > TONE3_HALF) ? HALF_12 : TONE3_HALF;
    localparam int HALF_W   = $clog2(HALF_MAX + 1);

    localparam int HC_MAX = (MIN_HOLD_TICKS > GAP_TICKS) ? MIN_HOLD_TICKS : GAP_TICKS;
    localparam int HC_W   = (HC_MAX < 1) ? 1 : $clog2(HC_MAX + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MIN_HOLD_TICKS);
    localparam logic [HC_W-1:0] GAP_LIM  = HC_W'(GAP_TICKS);
    localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;
    logic [1:0]        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [1:0]        tone_q, tone_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;

    logic [2:0]        req_win;
    logic [1:0]        tone_win;
    logic              owner_req;
    logic              higher_req;
    logic              restart;
    logic              gen_en;
    logic              sq;
    logic [HALF_W-1:0] half_sel;

    // Free-running prescaler; never disturbed by arbitration.
    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + PRE_ONE;

    assign req_win = lowest_onehot(req);

    always_comb begin
        tone_win = tone2;
        if (req[0])      tone_win = tone0;
        else if (req[1]) tone_win = tone1;
    end

    // grant_q - 1 turns the one-hot grant into a mask of the higher-priority
    // (lower-index) lines; only meaningful while a grant is held.
    assign owner_req  = |(req & grant_q);
    assign higher_req = |(req & (grant_q - 3'd1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tone_d  = tone_q;
        hcnt_d  = hcnt_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_HOLD;
                    grant_d = req_win;
                    tone_d  = tone_win;
                    hcnt_d  = '0;
                    restart = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hcnt_q == HOLD_LIM && (!owner_req || higher_req)) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    hcnt_d  = '0;
                end else if (tick && hcnt_q < HOLD_LIM) begin
                    hcnt_d = hcnt_q + HC_ONE;
                end
            end
            ST_GAP: begin
                // Checked before counting so GAP_TICKS=0 gives a one-clk gap.
                if (hcnt_q >= GAP_LIM) begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                end else if (tick) begin
                    hcnt_d = hcnt_q + HC_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                tone_d  = TONE_OFF;
                hcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            state_q <= ST_IDLE;
            grant_q <= '0;
            tone_q  <= TONE_OFF;
            hcnt_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            grant_q <= grant_d;
            tone_q  <= tone_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        case (tone_q)
            TONE_MID: half_sel = HALF_W'(TONE2_HALF);
            TONE_HI:  half_sel = HALF_W'(TONE3_HALF);
            default:  half_sel = HALF_W'(TONE1_HALF);
        endcase
    end

    assign gen_en = (state_q == ST_HOLD) && (tone_q != TONE_OFF);

    tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .half_period (half_sel),
        .en          (gen_en),
        .sq_out      (sq)
    );

    assign grant   = grant_q;
    assign busy    = (state_q == ST_HOLD) || (state_q == ST_GAP);
    assign aud_out = sq && gen_en;

endmodule
